note_player_multi: RTL and testbench
====================================

NOTE_PLAYER_MULTI -- requirements
Module: note_player_multi

Interface
REQ-001 The block SHALL have parameters:
- NUM_CHANNELS, 4, independent voices (2..8).
- PITCH_W, 6, pitch index width.
- DUR_W, 5, duration width.
- INSTR_W, 4, instrument index width.
- ENV_STEPS_W, 3, envelope step index width.
- ENV_W, 9, envelope output width.
- ROM_AW, 8, ROM address width.
- ROM_DW, 16, ROM data width.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low. Ports (name, direction, width, meaning):
- i_clk, in, 1, clock.
- i_rst_n, in, 1, async active-low reset.
- i_frame_stb, in, 1, start one update pass over all channels.
- i_note_stb, in, 1, note tick for duration counting.
- i_load, in, 1, load note into channel i_chan.
- i_chan, in, CW=$clog2(NUM_CHANNELS), target channel.
- i_pitch, in, PITCH_W, pitch index.
- i_duration, in, DUR_W, note length in ticks.
- i_instrument, in, INSTR_W, instrument index.
- o_valid, out, 1, one-cycle result strobe.
- o_chan, out, CW, channel of current result.
- o_phase_delta, out, 2*ROM_DW, oscillator phase increment.
- o_envelope, out, ENV_W, amplitude.
- o_done, out, NUM_CHANNELS, per-channel note-end pulse.
- o_busy, out, 1, update pass in progress.
- o_overrun, out, 1, frame strobe dropped.
- o_rom_addr, out, ROM_AW, shared sync ROM address.
- i_rom_data, in, ROM_DW, ROM data, valid one cycle after address.

Function
REQ-003 ROM map SHALL be: phase hi at {0,pitch,0}, phase lo at {0,pitch,1}; envelope at {1,instrument,step}, value = i_rom_data[ENV_W-1:0].
REQ-004 Per channel the block SHALL hold pitch, instrument, duration counter, envelope step, and active flag.
REQ-005 On i_load the block SHALL store pitch/instrument/duration for i_chan, set active=1, and clear its envelope step to 0.
REQ-006 On i_note_stb each active channel SHALL, if counter==0, clear active and pulse o_done[c] for one cycle; otherwise decrement. A note of duration d therefore ends on the (d+1)th tick.
REQ-007 When i_load and i_note_stb hit the same channel in the same cycle, the load SHALL win with no decrement and no done.
REQ-008 The FSM SHALL have states IDLE, HI, LO, ENV, OUT. An i_frame_stb in IDLE SHALL enter HI with channel 0.
REQ-009 Each state SHALL occupy one cycle:
- HI: snapshot the channel's pitch/instrument/step/active; drive the hi address.
- LO: capture hi; drive the lo address.
- ENV: capture lo; drive the envelope address.
- OUT: capture the envelope; assert o_valid with o_chan.
REQ-010 OUT SHALL advance to HI of the next channel, or to IDLE after channel NUM_CHANNELS-1. A pass SHALL take 4*NUM_CHANNELS cycles; the first o_valid SHALL occur 4 cycles after i_frame_stb.
REQ-011 An inactive channel SHALL still emit o_valid, with o_phase_delta=0 and o_envelope=0.
REQ-012 In OUT, an active channel's envelope step SHALL increment, saturating at 2^ENV_STEPS_W-1.
REQ-013 A load during a pass SHALL update registers immediately; a channel already snapshotted SHALL use the new values on the next frame.
REQ-014 i_frame_stb while not IDLE SHALL be ignored and SHALL pulse o_overrun for one cycle.
REQ-015 o_busy SHALL be 1 in every non-IDLE state. Outputs SHALL be registered.

Reset
REQ-016 Asserting i_rst_n low SHALL immediately force the FSM to IDLE and clear all channel state. All outputs SHALL be 0, including o_rom_addr.
REQ-017 Reset mid-pass SHALL abort the pass with no further o_valid; the first frame after release SHALL start at channel 0.

Structure
REQ-018 The ROM map base constants, the FSM state enum and the default widths SHALL live in note_player_pkg.
REQ-019 The core SHALL have no sub-module. The bench SHALL pair it with rom_sync_fake (WIDTH=ROM_DW, DEPTH=2^ROM_AW).

Verification
REQ-020 ROM mem[10]=16'h0012, mem[11]=16'h3456, mem[128+8+0]=9'h1FF (instrument 1, step 0); load ch0 pitch=5, instr=1, dur=3; frame. Required: ch0 o_valid 4 cycles later with phase=32'h00123456, env=9'h1FF, and ch1..3 valid with phase=0, env=0.
REQ-021 Load ch2 dur=2 followed by three i_note_stb. Required: o_done[2] pulses on the 3rd tick only, and ch2 reports env=0 on the next frame.
REQ-022 Nine frames on an active channel. Required: envelope addresses step 0..7, then step stays at 7.
REQ-023 i_frame_stb 5 cycles into a pass. Required: o_overrun pulses once and the pass length stays 16 cycles.
REQ-024 Same-cycle load plus note_stb on ch1 with counter=0. Required: no o_done[1], and the counter equals the new i_duration.
REQ-025 i_rst_n low during the LO state. Required: outputs 0 at once, no o_valid, and the next frame starts at o_chan=0.

Source files
------------

// File: rtl/note_player_pkg.sv
// Shared constants for the multi-channel note player: default widths,
// ROM segment map and the update-pass state encoding.
// No logic; imported by the core.
package note_player_pkg;

    // Default geometry of the player.
    localparam int NP_NUM_CHANNELS = 4;
    localparam int NP_PITCH_W      = 6;
    localparam int NP_DUR_W        = 5;
    localparam int NP_INSTR_W      = 4;
    localparam int NP_ENV_STEPS_W  = 3;
    localparam int NP_ENV_W        = 9;
    localparam int NP_ROM_AW       = 8;
    localparam int NP_ROM_DW       = 16;

    // ROM map: MSB selects the segment, the phase segment keeps the hi/lo
    // halves of the increment in adjacent words.
    localparam logic ROM_SEG_PHASE = 1'b0;
    localparam logic ROM_SEG_ENV   = 1'b1;
    localparam logic PHASE_HALF_HI = 1'b0;
    localparam logic PHASE_HALF_LO = 1'b1;

    // Update pass: one HI/LO/ENV/OUT round per channel.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HI,
        ST_LO,
        ST_ENV,
        ST_OUT
    } state_e;

endpackage

// File: rtl/rom_sync_fake.sv
// Purpose: synchronous single-read ROM stand-in with a write port for preloading.
// Latency: read data valid one cycle after the address.
// Backpressure: none; a read and a write may occur every cycle.
module rom_sync_fake #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_addr,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] data_q;

    // Registered read plus preload write port.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
        data_q <= mem_q[i_addr];
    end

    assign o_data = data_q;

endmodule

// File: rtl/note_player_multi.sv
// Purpose: per-channel note state plus a frame pass that looks up phase/envelope in a shared ROM.
// Latency: first o_valid 4 cycles after i_frame_stb, then one result per 4 cycles (4*NUM_CHANNELS pass).
// Backpressure: none; a frame strobe arriving mid-pass is dropped and flagged on o_overrun.
module note_player_multi
    import note_player_pkg::*;
#(
    parameter int NUM_CHANNELS = NP_NUM_CHANNELS,
    parameter int PITCH_W      = NP_PITCH_W,
    parameter int DUR_W        = NP_DUR_W,
    parameter int INSTR_W      = NP_INSTR_W,
    parameter int ENV_STEPS_W  = NP_ENV_STEPS_W,
    parameter int ENV_W        = NP_ENV_W,
    parameter int ROM_AW       = NP_ROM_AW,
    parameter int ROM_DW       = NP_ROM_DW
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_frame_stb,
    input  logic                            i_note_stb,
    input  logic                            i_load,
    input  logic [$clog2(NUM_CHANNELS)-1:0] i_chan,
    input  logic [PITCH_W-1:0]              i_pitch,
    input  logic [DUR_W-1:0]                i_duration,
    input  logic [INSTR_W-1:0]              i_instrument,
    output logic                            o_valid,
    output logic [$clog2(NUM_CHANNELS)-1:0] o_chan,
    output logic [2*ROM_DW-1:0]             o_phase_delta,
    output logic [ENV_W-1:0]                o_envelope,
    output logic [NUM_CHANNELS-1:0]         o_done,
    output logic                            o_busy,
    output logic                            o_overrun,
    output logic [ROM_AW-1:0]               o_rom_addr,
    input  logic [ROM_DW-1:0]               i_rom_data
);

    localparam int CW = $clog2(NUM_CHANNELS);
    localparam logic [ENV_STEPS_W-1:0] STEP_MAX = '1;

    state_e                                     state_q, state_d;
    logic [CW-1:0]                              chan_q, chan_d;

    logic [NUM_CHANNELS-1:0][PITCH_W-1:0]       pitch_q;
    logic [NUM_CHANNELS-1:0][INSTR_W-1:0]       instr_q;
    logic [NUM_CHANNELS-1:0][DUR_W-1:0]         dur_q;
    logic [NUM_CHANNELS-1:0][ENV_STEPS_W-1:0]   step_q;
    logic [NUM_CHANNELS-1:0]                    act_q;

    logic [NUM_CHANNELS-1:0]                    load_hit, done_d, step_inc;

    logic [PITCH_W-1:0]                         snap_pitch_q;
    logic [INSTR_W-1:0]                         snap_instr_q;
    logic [ENV_STEPS_W-1:0]                     snap_step_q;
    logic                                       snap_act_q;
    logic [ROM_DW-1:0]                          hi_q, lo_q;

    logic [ROM_AW-1:0]                          rom_addr_d, rom_addr_q;
    logic                                       valid_q, busy_q, overrun_q;
    logic [CW-1:0]                              out_chan_q;
    logic [2*ROM_DW-1:0]                        phase_q;
    logic [ENV_W-1:0]                           env_q;
    logic [NUM_CHANNELS-1:0]                    done_q;

    // Pass sequencing: four one-cycle states per channel, channel 0 first.
    always_comb begin
        state_d = state_q;
        chan_d  = chan_q;
        case (state_q)
            ST_IDLE: begin
                if (i_frame_stb) begin
                    state_d = ST_HI;
                    chan_d  = '0;
                end
            end
            ST_HI:  state_d = ST_LO;
            ST_LO:  state_d = ST_ENV;
            ST_ENV: state_d = ST_OUT;
            ST_OUT: begin
                if (chan_q == CW'(NUM_CHANNELS - 1)) begin
                    state_d = ST_IDLE;
                    chan_d  = '0;
                end else begin
                    state_d = ST_HI;
                    chan_d  = chan_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ROM address is registered on entry to each state so the data lands in the following state.
    always_comb begin
        rom_addr_d = '0;
        case (state_d)
            ST_HI:   rom_addr_d = ROM_AW'({ROM_SEG_PHASE, pitch_q[chan_d], PHASE_HALF_HI});
            ST_LO:   rom_addr_d = ROM_AW'({ROM_SEG_PHASE, snap_pitch_q, PHASE_HALF_LO});
            ST_ENV:  rom_addr_d = ROM_AW'({ROM_SEG_ENV, snap_instr_q, snap_step_q});
            default: rom_addr_d = '0;
        endcase
    end

    // Per-channel decode: a load on the same channel overrides tick and envelope advance.
    always_comb begin
        load_hit = '0;
        done_d   = '0;
        step_inc = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            load_hit[c] = i_load && (i_chan == CW'(c));
            done_d[c]   = i_note_stb && act_q[c] && (dur_q[c] == '0) && !load_hit[c];
            step_inc[c] = (state_q == ST_OUT) && (chan_q == CW'(c)) && snap_act_q
                          && act_q[c] && (step_q[c] != STEP_MAX);
        end
    end

    // FSM state and channel pointer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            chan_q  <= '0;
        end else begin
            state_q <= state_d;
            chan_q  <= chan_d;
        end
    end

    // Channel registers: load, duration countdown, envelope step advance.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pitch_q <= '0;
            instr_q <= '0;
            dur_q   <= '0;
            step_q  <= '0;
            act_q   <= '0;
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (load_hit[c]) begin
                    pitch_q[c] <= i_pitch;
                    instr_q[c] <= i_instrument;
                    dur_q[c]   <= i_duration;
                    step_q[c]  <= '0;
                    act_q[c]   <= 1'b1;
                end else begin
                    if (i_note_stb && act_q[c]) begin
                        if (dur_q[c] == '0) begin
                            act_q[c] <= 1'b0;
                        end else begin
                            dur_q[c] <= dur_q[c] - DUR_W'(1);
                        end
                    end
                    if (step_inc[c]) begin
                        step_q[c] <= step_q[c] + ENV_STEPS_W'(1);
                    end
                end
            end
        end
    end

    // Snapshot on entry to HI, then capture the hi/lo ROM words as they arrive.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            snap_pitch_q <= '0;
            snap_instr_q <= '0;
            snap_step_q  <= '0;
            snap_act_q   <= 1'b0;
            hi_q         <= '0;
            lo_q         <= '0;
        end else begin
            if (state_d == ST_HI) begin
                snap_pitch_q <= pitch_q[chan_d];
                snap_instr_q <= instr_q[chan_d];
                snap_step_q  <= step_q[chan_d];
                snap_act_q   <= act_q[chan_d];
            end
            if (state_q == ST_LO) begin
                hi_q <= i_rom_data;
            end
            if (state_q == ST_ENV) begin
                lo_q <= i_rom_data;
            end
        end
    end

    // Registered outputs; the envelope word is taken straight from the ROM at the end of OUT.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q    <= 1'b0;
            out_chan_q <= '0;
            phase_q    <= '0;
            env_q      <= '0;
            done_q     <= '0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
            rom_addr_q <= '0;
        end else begin
            valid_q    <= (state_q == ST_OUT);
            done_q     <= done_d;
            busy_q     <= (state_d != ST_IDLE);
            overrun_q  <= i_frame_stb && (state_q != ST_IDLE);
            rom_addr_q <= rom_addr_d;
            if (state_q == ST_OUT) begin
                out_chan_q <= chan_q;
                phase_q    <= snap_act_q ? {hi_q, lo_q} : '0;
                env_q      <= snap_act_q ? i_rom_data[ENV_W-1:0] : '0;
            end
        end
    end

    assign o_valid       = valid_q;
    assign o_chan        = out_chan_q;
    assign o_phase_delta = phase_q;
    assign o_envelope    = env_q;
    assign o_done        = done_q;
    assign o_busy        = busy_q;
    assign o_overrun     = overrun_q;
    assign o_rom_addr    = rom_addr_q;

endmodule

// File: tb/tb_note_player_multi.sv
module tb_note_player_multi;
    localparam int NC = 4;
    localparam int CW = 2;
    localparam int AW = 8;
    localparam int RW = 16;

    logic            i_clk = 1'b0;
    logic            i_rst_n = 1'b0;
    logic            i_frame_stb = 1'b0;
    logic            i_note_stb = 1'b0;
    logic            i_load = 1'b0;
    logic [CW-1:0]   i_chan = '0;
    logic [5:0]      i_pitch = '0;
    logic [4:0]      i_duration = '0;
    logic [3:0]      i_instrument = '0;
    logic            o_valid;
    logic [CW-1:0]   o_chan;
    logic [31:0]     o_phase_delta;
    logic [8:0]      o_envelope;
    logic [NC-1:0]   o_done;
    logic            o_busy;
    logic            o_overrun;
    logic [AW-1:0]   o_rom_addr;
    logic [RW-1:0]   i_rom_data;
    logic            rom_we = 1'b0;
    logic [AW-1:0]   rom_waddr = '0;
    logic [RW-1:0]   rom_wdata = '0;

    always #5 i_clk = ~i_clk;

    note_player_multi dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_frame_stb(i_frame_stb), .i_note_stb(i_note_stb),
        .i_load(i_load), .i_chan(i_chan), .i_pitch(i_pitch), .i_duration(i_duration),
        .i_instrument(i_instrument), .o_valid(o_valid), .o_chan(o_chan),
        .o_phase_delta(o_phase_delta), .o_envelope(o_envelope), .o_done(o_done),
        .o_busy(o_busy), .o_overrun(o_overrun), .o_rom_addr(o_rom_addr), .i_rom_data(i_rom_data)
    );

    rom_sync_fake #(.WIDTH(RW), .DEPTH(1 << AW)) rom (
        .i_clk(i_clk), .i_we(rom_we), .i_waddr(rom_waddr), .i_wdata(rom_wdata),
        .i_addr(o_rom_addr), .o_data(i_rom_data)
    );

    int checks = 0;
    int failures = 0;

    // Behavioural model: ROM image and per-channel note state.
    logic [RW-1:0] rom_m [1 << AW];
    logic [5:0]    m_pitch [NC];
    logic [3:0]    m_instr [NC];
    int            m_dur [NC];
    int            m_step [NC];
    bit            m_act [NC];

    // Values captured in the latest frame, indexed by channel.
    logic [31:0]   cap_ph [NC];
    logic [8:0]    cap_env [NC];

    typedef struct {
        logic [CW-1:0] ch;
        logic [5:0]    pitch;
        logic [3:0]    instr;
        logic [4:0]    dur;
        logic [15:0]   hi, lo, env;
        logic [31:0]   exp_ph;
        logic [8:0]    exp_env;
    } vec_t;
    vec_t tab [4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic model_reset();
        for (int c = 0; c < NC; c++) begin
            m_pitch[c] = '0; m_instr[c] = '0; m_dur[c] = 0; m_step[c] = 0; m_act[c] = 0;
        end
    endtask

    task automatic rom_wr(input logic [AW-1:0] a, input logic [RW-1:0] d);
        rom_we = 1'b1; rom_waddr = a; rom_wdata = d;
        rom_m[a] = d;
        tick();
        rom_we = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 64'(o_valid), 0);
        chk({tag, "_busy"}, 64'(o_busy), 0);
        chk({tag, "_ovr"}, 64'(o_overrun), 0);
        chk({tag, "_done"}, 64'(o_done), 0);
        chk({tag, "_addr"}, 64'(o_rom_addr), 0);
        chk({tag, "_phase"}, 64'(o_phase_delta), 0);
        chk({tag, "_env"}, 64'(o_envelope), 0);
        chk({tag, "_chan"}, 64'(o_chan), 0);
    endtask

    task automatic reset_dut();
        i_rst_n = 1'b0;
        tick(); tick();
        i_rst_n = 1'b1;
        tick();
        model_reset();
    endtask

    task automatic do_load(input int c, input logic [5:0] p, input logic [3:0] ins, input logic [4:0] d);
        i_load = 1'b1; i_chan = CW'(c); i_pitch = p; i_instrument = ins; i_duration = d;
        m_pitch[c] = p; m_instr[c] = ins; m_dur[c] = int'(d); m_step[c] = 0; m_act[c] = 1;
        tick();
        i_load = 1'b0;
    endtask

    // Note tick, optionally with a simultaneous load; the load takes priority on its channel.
    task automatic do_note(input string tag, input bit with_load, input int lc,
                           input logic [5:0] p, input logic [3:0] ins, input logic [4:0] d);
        logic [NC-1:0] exp_done;
        exp_done = '0;
        for (int c = 0; c < NC; c++) begin
            if (with_load && c == lc) begin
                m_pitch[c] = p; m_instr[c] = ins; m_dur[c] = int'(d); m_step[c] = 0; m_act[c] = 1;
            end else if (m_act[c]) begin
                if (m_dur[c] == 0) begin
                    m_act[c] = 0;
                    exp_done[c] = 1'b1;
                end else begin
                    m_dur[c]--;
                end
            end
        end
        i_note_stb = 1'b1;
        i_load = with_load; i_chan = CW'(lc); i_pitch = p; i_instrument = ins; i_duration = d;
        tick();
        i_note_stb = 1'b0; i_load = 1'b0;
        chk({tag, "_done"}, 64'(o_done), 64'(exp_done));
        tick();
        chk({tag, "_done_clr"}, 64'(o_done), 0);
    endtask

    // One full update pass compared against the model; inject_at >= 0 fires an extra strobe mid-pass.
    task automatic check_frame(input string tag, input int inject_at);
        logic [31:0]   e_ph [NC];
        logic [8:0]    e_env [NC];
        logic [AW-1:0] e_addr0, a0;
        logic [RW-1:0] w;
        int            vt [NC];
        logic [CW-1:0] vc [NC];
        int nv, busy, ovr;
        nv = 0; busy = 0; ovr = 0; a0 = '0;
        e_addr0 = {1'b1, m_instr[0], 3'(m_step[0])};
        for (int c = 0; c < NC; c++) begin
            if (m_act[c]) begin
                e_ph[c] = {rom_m[{1'b0, m_pitch[c], 1'b0}], rom_m[{1'b0, m_pitch[c], 1'b1}]};
                w = rom_m[{1'b1, m_instr[c], 3'(m_step[c])}];
                e_env[c] = w[8:0];
                if (m_step[c] < 7) m_step[c]++;
            end else begin
                e_ph[c] = '0;
                e_env[c] = '0;
            end
        end
        i_frame_stb = 1'b1;
        tick();
        i_frame_stb = 1'b0;
        for (int t = 0; t < 4 * NC + 4; t++) begin
            if (o_busy) busy++;
            if (o_overrun) ovr++;
            if (t == 2) a0 = o_rom_addr;
            if (o_valid) begin
                if (nv < NC) begin
                    vt[nv] = t; vc[nv] = o_chan;
                    cap_ph[o_chan] = o_phase_delta; cap_env[o_chan] = o_envelope;
                end
                nv++;
            end
            if (t == inject_at) i_frame_stb = 1'b1;
            tick();
            i_frame_stb = 1'b0;
        end
        chk({tag, "_nvalid"}, 64'(nv), 64'(NC));
        chk({tag, "_busy_len"}, 64'(busy), 64'(4 * NC));
        chk({tag, "_overrun"}, 64'(ovr), (inject_at >= 0) ? 64'd1 : 64'd0);
        chk({tag, "_env_addr0"}, 64'(a0), 64'(e_addr0));
        for (int i = 0; i < NC; i++) begin
            if (i < nv) begin
                chk({tag, "_chan"}, 64'(vc[i]), 64'(i));
                chk({tag, "_lat"}, 64'(vt[i]), 64'(4 + 4 * i));
                chk({tag, "_phase"}, 64'(cap_ph[i]), 64'(e_ph[i]));
                chk({tag, "_env"}, 64'(cap_env[i]), 64'(e_env[i]));
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int r;
        tab[0] = '{ch: 2'd0, pitch: 6'd5,  instr: 4'd1,  dur: 5'd3,  hi: 16'h0012, lo: 16'h3456,
                   env: 16'h01FF, exp_ph: 32'h0012_3456, exp_env: 9'h1FF};
        tab[1] = '{ch: 2'd1, pitch: 6'd9,  instr: 4'd2,  dur: 5'd7,  hi: 16'hABCD, lo: 16'h0001,
                   env: 16'hFE37, exp_ph: 32'hABCD_0001, exp_env: 9'h037};
        tab[2] = '{ch: 2'd2, pitch: 6'd63, instr: 4'd15, dur: 5'd31, hi: 16'hFFFF, lo: 16'h8000,
                   env: 16'h0100, exp_ph: 32'hFFFF_8000, exp_env: 9'h100};
        tab[3] = '{ch: 2'd3, pitch: 6'd0,  instr: 4'd0,  dur: 5'd0,  hi: 16'h7E01, lo: 16'h00FF,
                   env: 16'h0A55, exp_ph: 32'h7E01_00FF, exp_env: 9'h055};

        // Reset state, with the ROM preloaded while the core is held in reset.
        model_reset();
        tick();
        chk_all_zero("reset");
        for (int a = 0; a < (1 << AW); a++) rom_wr(AW'(a), RW'($urandom));
        chk_all_zero("reset_hold");
        i_rst_n = 1'b1;
        tick();

        // Table vectors: one loaded channel per frame, others must read as zero.
        for (int k = 0; k < 4; k++) begin
            reset_dut();
            rom_wr({1'b0, tab[k].pitch, 1'b0}, tab[k].hi);
            rom_wr({1'b0, tab[k].pitch, 1'b1}, tab[k].lo);
            rom_wr({1'b1, tab[k].instr, 3'd0}, tab[k].env);
            do_load(int'(tab[k].ch), tab[k].pitch, tab[k].instr, tab[k].dur);
            check_frame("tab", -1);
            chk("tab_phase_const", 64'(cap_ph[tab[k].ch]), 64'(tab[k].exp_ph));
            chk("tab_env_const", 64'(cap_env[tab[k].ch]), 64'(tab[k].exp_env));
        end

        // Duration 2 ends on the third tick; next frame reports the channel silent.
        reset_dut();
        do_load(2, 6'd12, 4'd4, 5'd2);
        do_note("dur2_t1", 0, 0, '0, '0, '0);
        do_note("dur2_t2", 0, 0, '0, '0, '0);
        do_note("dur2_t3", 0, 0, '0, '0, '0);
        chk("dur2_inactive", 64'(m_act[2]), 0);
        check_frame("dur2_frame", -1);
        chk("dur2_env_zero", 64'(cap_env[2]), 0);

        // Envelope step walks 0..7 and then holds at 7.
        reset_dut();
        for (int s = 0; s < 8; s++) rom_wr({1'b1, 4'd3, 3'(s)}, RW'(37 * s + 5));
        do_load(0, 6'd7, 4'd3, 5'd31);
        for (int f = 0; f < 9; f++) check_frame("env_walk", -1);

        // Frame strobe mid-pass is dropped and flagged once.
        check_frame("overrun", 5);

        // Load and tick on the same channel whose counter is already zero.
        reset_dut();
        do_load(1, 6'd20, 4'd6, 5'd0);
        do_note("same_cyc", 1, 1, 6'd21, 4'd6, 5'd2);
        do_note("same_t1", 0, 0, '0, '0, '0);
        do_note("same_t2", 0, 0, '0, '0, '0);
        do_note("same_t3", 0, 0, '0, '0, '0);

        // Reset asserted while the pass sits in LO.
        reset_dut();
        do_load(0, 6'd33, 4'd2, 5'd20);
        do_load(3, 6'd44, 4'd9, 5'd20);
        i_frame_stb = 1'b1;
        tick();
        i_frame_stb = 1'b0;
        tick();
        chk("lo_busy_pre", 64'(o_busy), 1);
        i_rst_n = 1'b0;
        #1;
        chk_all_zero("mid_rst");
        r = 0;
        for (int t = 0; t < 8; t++) begin
            if (t == 2) i_rst_n = 1'b1;
            tick();
            if (o_valid) r++;
        end
        chk("mid_rst_no_valid", 64'(r), 0);
        model_reset();
        check_frame("after_rst", -1);

        // Randomized traffic against the model.
        reset_dut();
        for (int it = 0; it < 60; it++) begin
            r = int'($urandom_range(0, 9));
            if (r <= 3) begin
                do_load(int'($urandom_range(0, NC - 1)), 6'($urandom), 4'($urandom), 5'($urandom_range(0, 6)));
            end else if (r <= 6) begin
                do_note("rnd_note", 0, 0, '0, '0, '0);
            end else if (r == 7) begin
                do_note("rnd_note_ld", 1, int'($urandom_range(0, NC - 1)), 6'($urandom), 4'($urandom),
                        5'($urandom_range(0, 6)));
            end else begin
                check_frame("rnd_frame", -1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
